// File: rtl/coproc_pkg.sv
// rtl/coproc_pkg.sv - shared constants and state encoding for the coprocessor command/readback path
//
// Purpose: ASCII constants, BRAM geometry and the streamer state enum shared by
// the command FSM and the BRAM read-back streamer.
// Ports: none (package).

package coproc_pkg;

  localparam int BRAM_DEPTH = 1024;

  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_D    = 8'h44;
  localparam logic [7:0] ASCII_E    = 8'h45;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_FMT,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_SEND_D,
    ST_DONE
  } streamer_state_t;

  // Decimal digit (0..9) to its ASCII character.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'b0000, d};
  endfunction

endpackage

// File: rtl/byte_to_dec_ascii.sv
// rtl/byte_to_dec_ascii.sv - registered 8-bit to 1..3 digit ASCII decimal converter
//
// Purpose: converts a byte into hundreds/tens/units ASCII characters plus the
// number of significant digits (leading zeros suppressed, 0 gives one digit).
// One clock of latency: results update on the edge where load=1.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture value on this edge
//   value        byte to convert
//   char_hund    ASCII hundreds digit
//   char_tens    ASCII tens digit
//   char_unit    ASCII units digit
//   num_digits   significant digit count, 1..3

module byte_to_dec_ascii
  import coproc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  output logic [7:0] char_hund,
  output logic [7:0] char_tens,
  output logic [7:0] char_unit,
  output logic [1:0] num_digits
);

  logic [1:0] hund;
  logic [7:0] rem;
  logic [3:0] tens;
  logic [3:0] unit;
  logic [1:0] ndig;

  // Hundreds by two compares, tens by a compare ladder against multiples of 10.
  always_comb begin
    hund = 2'd0;
    rem  = value;
    if (value >= 8'd200) begin
      hund = 2'd2;
      rem  = value - 8'd200;
    end else if (value >= 8'd100) begin
      hund = 2'd1;
      rem  = value - 8'd100;
    end
    tens = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if (rem >= 8'(k * 10)) tens = 4'(k);
    end
    unit = 4'(rem - ({4'b0000, tens} * 8'd10));
    if (hund != 2'd0)      ndig = 2'd3;
    else if (tens != 4'd0) ndig = 2'd2;
    else                   ndig = 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_hund  <= 8'h00;
      char_tens  <= 8'h00;
      char_unit  <= 8'h00;
      num_digits <= 2'd0;
    end else if (load) begin
      char_hund  <= digit_char({2'b00, hund});
      char_tens  <= digit_char(tens);
      char_unit  <= digit_char(unit);
      num_digits <= ndig;
    end
  end

endmodule

// File: rtl/bram_ascii_streamer.sv
// rtl/bram_ascii_streamer.sv - dumps BRAM[0..n-1] to the UART as LF-terminated decimal lines
//
// Purpose: reads num_words bytes from BRAM port B starting at address 0, sends
// each as ASCII decimal text plus LF, then sends "D",LF and pulses done.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle dump request (ignored while busy)
//   num_words    words to dump, clamped to the BRAM depth
//   enb, addrb   BRAM port-B read enable/address
//   doutb        BRAM port-B read data, RD_LATENCY cycles after enb
//   tx_start     one-cycle UART launch pulse, tx_data valid with it
//   tx_busy      UART transmitter busy
//   busy         dump in progress
//   done         one-cycle pulse after the terminator has been accepted

module bram_ascii_streamer
  import coproc_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH),
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  streamer_state_t state, next_state;

  logic [ADDR_WIDTH:0] cnt;
  logic [ADDR_WIDTH:0] idx;
  logic [ADDR_WIDTH:0] idx_inc;
  logic [ADDR_WIDTH:0] start_words;
  logic [1:0]          lat_cnt;
  logic [1:0]          hi_cnt;
  // Send queue: head byte in [31:24], q_cnt bytes valid.
  logic [31:0]         q_data;
  logic [2:0]          q_cnt;
  logic                term;

  logic       rd_ready;
  logic       conv_load;
  logic       hi_timeout;
  logic       q_last;
  logic       words_done;
  logic [7:0] char_hund, char_tens, char_unit;
  logic [1:0] num_digits;

  assign start_words = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  assign idx_inc     = idx + (ADDR_WIDTH + 1)'(1);
  assign words_done  = (idx_inc == cnt);
  assign rd_ready    = (lat_cnt == 2'(RD_LATENCY - 1));
  assign conv_load   = (state == ST_RD_WAIT) && rd_ready;
  // Fourth WAIT_HI cycle with tx_busy still low: treat the byte as taken.
  assign hi_timeout  = (hi_cnt == 2'd3);
  assign q_last      = (q_cnt == 3'd1);

  byte_to_dec_ascii u_conv (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (conv_load),
    .value      (doutb),
    .char_hund  (char_hund),
    .char_tens  (char_tens),
    .char_unit  (char_unit),
    .num_digits (num_digits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start) next_state = (start_words == '0) ? ST_SEND_D : ST_RD_REQ;
      ST_RD_REQ:  next_state = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_ready) next_state = ST_FMT;
      ST_FMT:     next_state = ST_SEND;
      ST_SEND:    if (!tx_busy) next_state = ST_WAIT_HI;
      ST_WAIT_HI: if (tx_busy || hi_timeout) next_state = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (!q_last)         next_state = ST_SEND;
          else if (term)       next_state = ST_DONE;
          else if (words_done) next_state = ST_SEND_D;
          else                 next_state = ST_RD_REQ;
        end
      end
      ST_SEND_D:  next_state = ST_SEND;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    enb      = 1'b0;
    addrb    = '0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_DONE: done = 1'b1;
      default: busy = 1'b1;
    endcase
    if (state == ST_RD_REQ) begin
      enb   = 1'b1;
      addrb = idx[ADDR_WIDTH-1:0];
    end
    if (state == ST_SEND && !tx_busy) begin
      tx_start = 1'b1;
      tx_data  = q_data[31:24];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      lat_cnt <= 2'd0;
      hi_cnt  <= 2'd0;
      q_data  <= 32'h0;
      q_cnt   <= 3'd0;
      term    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt  <= start_words;
            idx  <= '0;
            term <= 1'b0;
          end
        end
        ST_RD_REQ:  lat_cnt <= 2'd0;
        ST_RD_WAIT: lat_cnt <= lat_cnt + 2'd1;
        ST_FMT: begin
          case (num_digits)
            2'd3: begin
              q_data <= {char_hund, char_tens, char_unit, ASCII_LF};
              q_cnt  <= 3'd4;
            end
            2'd2: begin
              q_data <= {char_tens, char_unit, ASCII_LF, 8'h00};
              q_cnt  <= 3'd3;
            end
            default: begin
              q_data <= {char_unit, ASCII_LF, 16'h0000};
              q_cnt  <= 3'd2;
            end
          endcase
        end
        ST_SEND: hi_cnt <= 2'd0;
        ST_WAIT_HI: if (!tx_busy) hi_cnt <= hi_cnt + 2'd1;
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            q_data <= {q_data[23:0], 8'h00};
            q_cnt  <= q_cnt - 3'd1;
            if (q_last && !term) idx <= idx_inc;
          end
        end
        ST_SEND_D: begin
          q_data <= {ASCII_D, ASCII_LF, 16'h0000};
          q_cnt  <= 3'd2;
          term   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_ascii_streamer.sv
// tb/tb_bram_ascii_streamer.sv - self-checking bench for bram_ascii_streamer
//
// Purpose: drives dumps against a BRAM model and a UART model, compares the
// transmitted byte stream, read addresses and handshakes with a decimal-text model.
// Ports: none.

module tb_bram_ascii_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, start2;
  logic [10:0] num_words, num_words2;
  logic        enb, enb2;
  logic [9:0]  addrb, addrb2;
  logic [7:0]  doutb, doutb2;
  logic        tx_start, tx_start2;
  logic [7:0]  tx_data, tx_data2;
  logic        tx_busy = 1'b0;
  logic        tx_busy2;
  logic        busy, busy2;
  logic        done, done2;

  assign tx_busy2 = 1'b0;

  bram_ascii_streamer #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .enb(enb), .addrb(addrb), .doutb(doutb),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .busy(busy), .done(done)
  );

  bram_ascii_streamer #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .RD_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .num_words(num_words2),
    .enb(enb2), .addrb(addrb2), .doutb(doutb2),
    .tx_start(tx_start2), .tx_data(tx_data2), .tx_busy(tx_busy2),
    .busy(busy2), .done(done2)
  );

  logic [7:0] bram [0:1023];

  // BRAM models: data is valid only in the exact latency cycle, noise otherwise.
  logic       p1_valid = 1'b0;
  logic [7:0] p1_data  = 8'h00;
  always @(posedge clk) begin
    doutb    <= enb ? bram[addrb] : 8'($urandom);
    p1_valid <= enb2;
    p1_data  <= bram[addrb2];
    doutb2   <= p1_valid ? p1_data : 8'($urandom);
  end

  // UART model and monitors for the latency-1 instance.
  bit         busy_mode = 1'b0;
  bit         rand_hold = 1'b0;
  int         busy_left = 0;
  int         viol = 0;
  int         done_cnt = 0;
  bit         prev_start = 1'b0;
  logic [7:0] got[$];
  logic [9:0] addrs[$];
  always @(negedge clk) begin
    if (busy_left != 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy <= 1'b0;
    end
    if (tx_start === 1'b1) begin
      if (tx_busy) viol++;
      if (prev_start) viol++;
      got.push_back(tx_data);
      if (busy_mode) begin
        tx_busy   <= 1'b1;
        busy_left = rand_hold ? int'($urandom_range(12, 3)) : 3;
      end
    end
    prev_start = (tx_start === 1'b1);
    if (enb === 1'b1) addrs.push_back(addrb);
    if (done === 1'b1) done_cnt++;
  end

  logic [7:0] got2[$];
  int         done2_cnt = 0;
  always @(negedge clk) begin
    if (tx_start2 === 1'b1) got2.push_back(tx_data2);
    if (done2 === 1'b1) done2_cnt++;
  end

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: each word as its decimal text plus LF, then "D" LF.
  task automatic build_exp(input int n);
    int    m;
    string s;
    exp.delete();
    m = (n > 1024) ? 1024 : n;
    for (int i = 0; i < m; i++) begin
      s = $sformatf("%0d", bram[i]);
      for (int k = 0; k < s.len(); k++) exp.push_back(s[k]);
      exp.push_back(8'h0A);
    end
    exp.push_back("D");
    exp.push_back(8'h0A);
  endtask

  task automatic check_stream(input string tag, input int gbase);
    int ng;
    int mism;
    ng   = got.size() - gbase;
    mism = 0;
    check({tag, " byte count"}, ng, exp.size());
    for (int i = 0; i < ng && i < exp.size(); i++)
      if (got[gbase + i] !== exp[i]) mism++;
    check({tag, " byte mismatches"}, mism, 0);
  endtask

  task automatic run_dump(input int n, input bit inject, input string tag);
    int gbase, abase, dbase, cyc, busy_low, na, mism, m;
    gbase = got.size();
    abase = addrs.size();
    dbase = done_cnt;
    build_exp(n);
    @(negedge clk);
    num_words = 11'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    busy_low = 0;
    while (cyc < 60000) begin
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_low++;
      if (inject && cyc == 20) begin
        start = 1'b1;
        num_words = 11'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " finished in budget"}, (cyc < 60000), 1);
    // Start coincident with done must be dropped.
    start = 1'b1;
    num_words = 11'd5;
    @(negedge clk);
    start = 1'b0;
    check({tag, " start in done cycle ignored"}, busy, 1'b0);
    repeat (3) @(negedge clk);
    check({tag, " busy low cycles before done"}, busy_low, 0);
    check({tag, " done pulses"}, done_cnt - dbase, 1);
    check_stream(tag, gbase);
    m    = (n > 1024) ? 1024 : n;
    na   = addrs.size() - abase;
    mism = 0;
    check({tag, " enb count"}, na, m);
    for (int i = 0; i < na && i < m; i++)
      if (addrs[abase + i] !== 10'(i)) mism++;
    check({tag, " address sequence"}, mism, 0);
  endtask

  initial begin
    int gb, cyc, n;
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    num_words = '0;
    num_words2 = '0;
    repeat (3) @(negedge clk);
    check("reset outputs dut", {enb, addrb, tx_start, tx_data, busy, done}, 0);
    check("reset outputs dut2", {enb2, addrb2, tx_start2, tx_data2, busy2, done2}, 0);
    rst_n = 1'b1;

    bram[0] = 8'd0; bram[1] = 8'd42; bram[2] = 8'd255;
    busy_mode = 1'b1;
    run_dump(3, 1'b1, "three words uart busy");
    busy_mode = 1'b0;
    run_dump(3, 1'b0, "three words busy tied low");
    run_dump(0, 1'b0, "zero words");

    for (int i = 0; i < 64; i++) bram[i] = 8'($urandom);
    busy_mode = 1'b1;
    rand_hold = 1'b1;
    n = int'($urandom_range(40, 5));
    run_dump(n, 1'b1, "random words long gaps");
    rand_hold = 1'b0;

    for (int i = 0; i < 1024; i++) bram[i] = 8'(i % 256);
    run_dump(1024, 1'b0, "full depth");
    busy_mode = 1'b0;
    run_dump(2047, 1'b0, "clamped count");
    check("tx_start protocol violations", viol, 0);

    bram[0] = 8'd100;
    build_exp(1);
    @(negedge clk);
    num_words2 = 11'd1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("latency2 finished in budget", (cyc < 2000), 1);
    check("latency2 byte count", got2.size(), exp.size());
    for (int i = 0; i < got2.size() && i < exp.size(); i++)
      check($sformatf("latency2 byte %0d", i), got2[i], exp[i]);
    repeat (2) @(negedge clk);
    check("latency2 done pulses", done2_cnt, 1);

    bram[0] = 8'd0; bram[1] = 8'd42; bram[2] = 8'd255;
    busy_mode = 1'b1;
    gb = got.size();
    @(negedge clk);
    num_words = 11'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while ((got.size() - gb) < 2 && cyc < 500) begin
      start = (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("reset test reached second byte", (cyc < 500), 1);
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", {enb, addrb, tx_start, tx_data, busy, done}, 0);
    gb = got.size();
    repeat (6) @(negedge clk);
    check("no tx_start during reset", got.size() - gb, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_dump(3, 1'b0, "restart after reset");
    check("tx_start protocol violations final", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
